// File: rtl/y86_dmem_if.sv
// ============================================================================
//  y86_dmem_if : request/response bundle between PIPE and the data-memory stage
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface y86_dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  icode;
    logic [63:0] valA;
    logic [63:0] valE;
    logic [63:0] valP;
    logic        resp_valid;
    logic [63:0] valM;
    logic        mem_error;
    logic        busy;

    modport master (
        output req_valid, icode, valA, valE, valP,
        input  req_ready, resp_valid, valM, mem_error, busy
    );

    modport slave (
        input  req_valid, icode, valA, valE, valP,
        output req_ready, resp_valid, valM, mem_error, busy
    );
endinterface

`default_nettype wire

// File: rtl/y86_dmem_stage.sv
// ============================================================================
//  y86_dmem_stage : Y86-64 data-memory stage, 8-byte little-endian accesses
//                   completed after LATENCY cycles via a req/resp handshake
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module y86_dmem_stage #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 64,
    parameter int LATENCY = 1
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    y86_dmem_if.slave    bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [63:0]         wdata_q, wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [63:0]         valm_q, valm_d;
    logic                mem_error_q, mem_error_d;

    logic [7:0]          mem_q [DEPTH];

    logic                w_rd;
    logic                w_wr;
    logic [ADDR_W-1:0]   w_addr;
    logic [63:0]         w_wdata;
    logic                w_in_range;
    logic                w_commit;
    logic [IDX_W-1:0]    w_idx;
    logic [63:0]         w_rdata;

    always_comb begin
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_addr  = bus.valE[ADDR_W-1:0];
        w_wdata = bus.valA;
        case (bus.icode)
            4'h4: w_wr = 1'b1;
            4'h5: w_rd = 1'b1;
            4'h8: begin
                w_wr    = 1'b1;
                w_wdata = bus.valP;
            end
            4'h9: begin
                w_rd   = 1'b1;
                w_addr = bus.valA[ADDR_W-1:0];
            end
            4'hA: w_wr = 1'b1;
            4'hB: begin
                w_rd   = 1'b1;
                w_addr = bus.valA[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    // Range test on the full address so huge values never alias into memory.
    assign w_in_range = (addr_q <= MAX_ADDR);
    assign w_idx      = addr_q[IDX_W-1:0];

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_rdata[8*k +: 8] = mem_q[w_idx + IDX_W'(k)];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        valm_d       = valm_q;
        mem_error_d  = mem_error_q;
        w_commit     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    rd_d    = w_rd;
                    wr_d    = w_wr;
                    addr_d  = w_addr;
                    wdata_d = w_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    w_commit     = 1'b1;
                    resp_valid_d = 1'b1;
                    valm_d       = (rd_q && w_in_range) ? w_rdata : 64'd0;
                    mem_error_d  = (rd_q || wr_q) && !w_in_range;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            valm_q       <= '0;
            mem_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            valm_q       <= valm_d;
            mem_error_q  <= mem_error_d;
        end
    end

    // Storage is deliberately not reset; an aborted op never reaches commit.
    always_ff @(posedge clk) begin
        if (w_commit && wr_q && w_in_range) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[w_idx + IDX_W'(k)] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.valM       = valm_q;
    assign bus.mem_error  = mem_error_q;

endmodule

`default_nettype wire
